// File: rtl/fb_pkg.sv
// Shared types and default geometry for the scaled frame buffer.
// Imported by the top so state names and frame constants stay in one place.
package fb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      SWAP_WAIT = 2'd2
   } fb_state_t;

   localparam int DEF_WIDTH  = 512;
   localparam int DEF_HEIGHT = 384;
   localparam int DEF_PIX_W  = 12;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// True dual-port, read-first, single-clock block RAM.
// HIGH_PERFORMANCE adds an output register (2-cycle read latency).
module xilinx_true_dual_port_read_first_1_clock_ram #(
   parameter int    RAM_WIDTH       = 12,
   parameter int    RAM_DEPTH       = 1024,
   parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
   parameter int    ADDR_W          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic                 clka,
   input  logic [ADDR_W-1:0]    addra,
   input  logic [ADDR_W-1:0]    addrb,
   input  logic [RAM_WIDTH-1:0] dina,
   input  logic [RAM_WIDTH-1:0] dinb,
   input  logic                 wea,
   input  logic                 web,
   input  logic                 ena,
   input  logic                 enb,
   input  logic                 rsta,
   input  logic                 rstb,
   input  logic                 regcea,
   input  logic                 regceb,
   output logic [RAM_WIDTH-1:0] douta,
   output logic [RAM_WIDTH-1:0] doutb
);

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_a;
   logic [RAM_WIDTH-1:0] ram_b;

   // Both ports in one process; reads see the pre-write contents.
   always_ff @(posedge clka) begin
      if (ena) begin
         if (wea)
            mem[addra] <= dina;
         ram_a <= mem[addra];
      end
      if (enb) begin
         if (web)
            mem[addrb] <= dinb;
         ram_b <= mem[addrb];
      end
   end

   if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
      assign douta = ram_a;
      assign doutb = ram_b;
   end else begin : g_high
      always_ff @(posedge clka) begin
         if (rsta)
            douta <= '0;
         else if (regcea)
            douta <= ram_a;
      end

      always_ff @(posedge clka) begin
         if (rstb)
            doutb <= '0;
         else if (regceb)
            doutb <= ram_b;
      end
   end

endmodule

// File: rtl/scaled_frame_buffer.sv
// Double-buffered frame store with integer upscaling on the display side.
// Writes land in the back bank; swaps happen only at vertical blank.
module scaled_frame_buffer
   import fb_pkg::*;
#(
   parameter int               WIDTH        = DEF_WIDTH,
   parameter int               HEIGHT       = DEF_HEIGHT,
   parameter int               SCALE_SHIFT  = 1,
   parameter int               PIX_W        = DEF_PIX_W,
   parameter int               DOUBLE_BUF   = 1,
   parameter logic [PIX_W-1:0] CLEAR_COLOR  = '0,
   parameter logic [PIX_W-1:0] BORDER_COLOR = '0
) (
   input  logic             clk_in,
   input  logic             rst_in_n,
   input  logic [10:0]      wr_x,
   input  logic [9:0]       wr_y,
   input  logic [PIX_W-1:0] wr_pixel,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             frame_done,
   input  logic             clear_req,
   input  logic [10:0]      rd_x,
   input  logic [9:0]       rd_y,
   input  logic             rd_valid,
   input  logic             vsync_in,
   output logic [PIX_W-1:0] pixel_out,
   output logic             pixel_valid_out,
   output logic             swap_done,
   output logic             clearing
);

   localparam int FRAME = WIDTH * HEIGHT;
   localparam int DEPTH = (1 + DOUBLE_BUF) * FRAME;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit DB    = (DOUBLE_BUF != 0);

   localparam logic [AW-1:0] FRAME_A = AW'(FRAME);
   localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
   localparam logic [AW-1:0] LAST_A  = AW'(FRAME - 1);

   fb_state_t state;
   fb_state_t state_nx;

   logic             pend;
   logic             pend_nx;
   logic             swap;
   logic             disp_bank;
   logic             wr_bank;
   logic             rdy;
   logic             clr_last;
   logic             rd_in;
   logic             wr_in;
   logic [10:0]      sx;
   logic [9:0]       sy;
   logic [AW-1:0]    clr_cnt;
   logic [AW-1:0]    wr_base;
   logic [AW-1:0]    rd_base;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    ra_q;
   logic [AW-1:0]    wb_addr;
   logic             wb_we;
   logic [PIX_W-1:0] wb_data;
   logic [PIX_W-1:0] douta;
   logic [PIX_W-1:0] unused_doutb;
   logic [2:0]       brd;
   logic [2:0]       vld;
   logic [2:0]       live;

   assign wr_bank = DB ? ~disp_bank : 1'b0;
   assign wr_base = wr_bank ? FRAME_A : '0;
   assign rd_base = disp_bank ? FRAME_A : '0;

   assign sx    = rd_x >> SCALE_SHIFT;
   assign sy    = rd_y >> SCALE_SHIFT;
   assign rd_in = ({21'd0, sx} < WIDTH) && ({22'd0, sy} < HEIGHT);
   assign wr_in = ({21'd0, wr_x} < WIDTH) && ({22'd0, wr_y} < HEIGHT);

   assign rd_addr = rd_base + AW'(sy) * WIDTH_A + AW'(sx);
   assign wr_addr = wr_base + AW'(wr_y) * WIDTH_A + AW'(wr_x);

   assign clr_last = (clr_cnt == LAST_A);

   always_comb begin
      state_nx = state;
      pend_nx  = pend;
      swap     = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_req) begin
               state_nx = CLEAR;
               pend_nx  = frame_done && DB;
            end else if (frame_done && DB) begin
               state_nx = SWAP_WAIT;
            end
         end
         CLEAR: begin
            if (frame_done && DB)
               pend_nx = 1'b1;
            if (clr_last) begin
               state_nx = pend_nx ? SWAP_WAIT : IDLE;
               pend_nx  = 1'b0;
            end
         end
         SWAP_WAIT: begin
            if (vsync_in) begin
               state_nx = IDLE;
               swap     = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Write port is registered so a write commits one cycle after acceptance.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state     <= IDLE;
         pend      <= 1'b0;
         disp_bank <= 1'b0;
         swap_done <= 1'b0;
         rdy       <= 1'b0;
         clr_cnt   <= '0;
         wb_we     <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
      end else begin
         state     <= state_nx;
         pend      <= pend_nx;
         swap_done <= swap;
         rdy       <= (state_nx == IDLE);
         if (swap)
            disp_bank <= ~disp_bank;
         clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
         wb_we   <= 1'b0;
         if (state == CLEAR) begin
            wb_we   <= 1'b1;
            wb_addr <= wr_base + clr_cnt;
            wb_data <= CLEAR_COLOR;
         end else if (wr_valid && rdy && wr_in) begin
            wb_we   <= 1'b1;
            wb_addr <= wr_addr;
            wb_data <= wr_pixel;
         end
      end
   end

   // live masks RAM output until the pipeline has refilled after reset.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         ra_q <= '0;
         brd  <= '0;
         vld  <= '0;
         live <= '0;
      end else begin
         ra_q <= rd_addr;
         brd  <= {brd[1:0], ~(rd_valid && rd_in)};
         vld  <= {vld[1:0], rd_valid};
         live <= {live[1:0], 1'b1};
      end
   end

   assign pixel_out = !live[2] ? '0
                    : brd[2]   ? BORDER_COLOR
                    :            douta;

   assign pixel_valid_out = vld[2];
   assign clearing        = (state == CLEAR);
   assign wr_ready        = rdy;

   xilinx_true_dual_port_read_first_1_clock_ram #(
      .RAM_WIDTH      (PIX_W),
      .RAM_DEPTH      (DEPTH),
      .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
      .ADDR_W         (AW)
   ) u_ram (
      .clka  (clk_in),
      .addra (ra_q),
      .addrb (wb_addr),
      .dina  ({PIX_W{1'b0}}),
      .dinb  (wb_data),
      .wea   (1'b0),
      .web   (wb_we),
      .ena   (1'b1),
      .enb   (1'b1),
      .rsta  (1'b0),
      .rstb  (1'b0),
      .regcea(1'b1),
      .regceb(1'b1),
      .douta (douta),
      .doutb (unused_doutb)
   );

endmodule

// File: tb/tb_scaled_frame_buffer.sv
// Directed bench for scaled_frame_buffer on a reduced 16x8 frame.
// Covers writes, scaled reads, clears, swaps and reset aborts.
module tb_scaled_frame_buffer;

   localparam int         W   = 16;
   localparam int         H   = 8;
   localparam logic [11:0] CLR = 12'h5A5;
   localparam logic [11:0] BRD = 12'hF0F;

   logic        clk_in;
   logic        rst_in_n;
   logic [10:0] wr_x;
   logic [9:0]  wr_y;
   logic [11:0] wr_pixel;
   logic        wr_valid;
   logic        wr_ready;
   logic        frame_done;
   logic        clear_req;
   logic [10:0] rd_x;
   logic [9:0]  rd_y;
   logic        rd_valid;
   logic        vsync_in;
   logic [11:0] pixel_out;
   logic        pixel_valid_out;
   logic        swap_done;
   logic        clearing;

   int checks = 0;
   int errors = 0;

   scaled_frame_buffer #(
      .WIDTH       (W),
      .HEIGHT      (H),
      .SCALE_SHIFT (1),
      .PIX_W       (12),
      .DOUBLE_BUF  (1),
      .CLEAR_COLOR (CLR),
      .BORDER_COLOR(BRD)
   ) dut (
      .clk_in         (clk_in),
      .rst_in_n       (rst_in_n),
      .wr_x           (wr_x),
      .wr_y           (wr_y),
      .wr_pixel       (wr_pixel),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .frame_done     (frame_done),
      .clear_req      (clear_req),
      .rd_x           (rd_x),
      .rd_y           (rd_y),
      .rd_valid       (rd_valid),
      .vsync_in       (vsync_in),
      .pixel_out      (pixel_out),
      .pixel_valid_out(pixel_valid_out),
      .swap_done      (swap_done),
      .clearing       (clearing)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int x, input int y, input logic [11:0] p);
      wr_x     = 11'(x);
      wr_y     = 10'(y);
      wr_pixel = p;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   // One-cycle read, then idle input; result appears after the third edge.
   task automatic rd_chk(input string tag, input int x, input int y,
                         input logic v, input logic [11:0] ep,
                         input logic ev);
      rd_x     = 11'(x);
      rd_y     = 10'(y);
      rd_valid = v;
      tick();
      rd_x     = '0;
      rd_y     = '0;
      rd_valid = 1'b0;
      tick();
      tick();
      check({tag, "_pix"}, 32'(pixel_out), 32'(ep));
      check({tag, "_vld"}, 32'(pixel_valid_out), 32'(ev));
   endtask

   task automatic run_clear(input int fd_at, input int vs_at,
                            output int n, output int sw, output int rh);
      n  = 0;
      sw = 0;
      rh = 0;
      while (clearing && n < 1000) begin
         n++;
         if (wr_ready)
            rh++;
         frame_done = (n == fd_at);
         vsync_in   = (n == vs_at);
         tick();
         if (swap_done)
            sw++;
      end
      frame_done = 1'b0;
      vsync_in   = 1'b0;
   endtask

   initial begin
      int n;
      int sw;
      int rh;

      rst_in_n   = 1'b0;
      wr_x       = '0;
      wr_y       = '0;
      wr_pixel   = '0;
      wr_valid   = 1'b0;
      frame_done = 1'b0;
      clear_req  = 1'b0;
      rd_x       = '0;
      rd_y       = '0;
      rd_valid   = 1'b0;
      vsync_in   = 1'b0;

      tick();
      tick();
      check("rst_wr_ready", 32'(wr_ready), 0);
      check("rst_pixel", 32'(pixel_out), 0);
      check("rst_pvalid", 32'(pixel_valid_out), 0);
      check("rst_swap", 32'(swap_done), 0);
      check("rst_clearing", 32'(clearing), 0);

      rst_in_n = 1'b1;
      #1;
      check("ready_pre_edge", 32'(wr_ready), 0);
      tick();
      check("ready_rise", 32'(wr_ready), 1);

      // Clear bank 1 with frame_done at cycle 10 and a stray vsync mid-clear.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("clr1_start", 32'(clearing), 1);
      run_clear(10, 20, n, sw, rh);
      check("clr1_cycles", 32'(n), W * H);
      check("clr1_no_swap", 32'(sw), 0);
      check("clr1_rdy_low", 32'(rh), 0);
      check("clr1_wait_rdy", 32'(wr_ready), 0);
      tick();
      check("clr1_wait_swap", 32'(swap_done), 0);
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      check("swap1_pulse", 32'(swap_done), 1);
      check("swap1_rdy", 32'(wr_ready), 1);
      tick();
      check("swap1_end", 32'(swap_done), 0);

      rd_chk("clr1_first", 0, 0, 1'b1, CLR, 1'b1);
      rd_chk("clr1_last", 31, 15, 1'b1, CLR, 1'b1);

      // Clear bank 0, now the write bank.
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      run_clear(0, 0, n, sw, rh);
      check("clr0_cycles", 32'(n), W * H);
      check("clr0_rdy", 32'(wr_ready), 1);

      wr(3, 2, 12'hABC);
      wr(600, 0, 12'h123);
      wr(5, 8, 12'h456);
      tick();
      rd_chk("oob_y_alias", 10, 0, 1'b1, CLR, 1'b1);

      // frame_done together with vsync must not swap on that vsync.
      frame_done = 1'b1;
      vsync_in   = 1'b1;
      tick();
      frame_done = 1'b0;
      vsync_in   = 1'b0;
      check("same_cyc_swap", 32'(swap_done), 0);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("wait_clr_ign", 32'(clearing), 0);
      check("wait_rdy", 32'(wr_ready), 0);
      tick();
      check("wait_no_swap", 32'(swap_done), 0);
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      check("swap2_pulse", 32'(swap_done), 1);
      tick();
      check("swap2_end", 32'(swap_done), 0);

      rd_chk("abc_6_4", 6, 4, 1'b1, 12'hABC, 1'b1);
      rd_chk("abc_7_5", 7, 5, 1'b1, 12'hABC, 1'b1);
      rd_chk("oob_x_alias", 16, 10, 1'b1, CLR, 1'b1);
      rd_chk("border_x", 1100, 0, 1'b1, BRD, 1'b1);
      rd_chk("border_y", 0, 16, 1'b1, BRD, 1'b1);
      rd_chk("rd_invalid", 0, 0, 1'b0, BRD, 1'b0);

      // Mark bank 1 and bank 0, swap, then abort a clear of bank 0.
      wr(1, 1, 12'h777);
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      vsync_in   = 1'b1;
      tick();
      vsync_in   = 1'b0;
      check("swap3_pulse", 32'(swap_done), 1);
      wr(8, 7, 12'h888);
      tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 100; i++)
         tick();
      check("mid_clear", 32'(clearing), 1);
      rst_in_n = 1'b0;
      #1;
      check("abort_clearing", 32'(clearing), 0);
      check("abort_rdy", 32'(wr_ready), 0);
      check("abort_pixel", 32'(pixel_out), 0);
      tick();
      rst_in_n = 1'b1;
      tick();
      check("abort_rdy_rise", 32'(wr_ready), 1);
      rd_chk("abort_bank0", 2, 2, 1'b1, CLR, 1'b1);
      rd_chk("abort_nowrite", 16, 14, 1'b1, 12'h888, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scaled_frame_buffer.md
SCALED_FRAME_BUFFER -- requirements
Module: scaled_frame_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 512, stored frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 384, stored frame height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, default 1, display-to-stored coordinate right-shift (0 = 1:1, 1 = 2x upscale).
REQ-004 SHALL have parameter PIX_W, default 12, pixel width ({r,g,b} 4:4:4 at default).
REQ-005 SHALL have parameter DOUBLE_BUF, default 1, 1 = two banks with swap, 0 = single bank.
REQ-006 SHALL have parameter CLEAR_COLOR, default 0, fill value for clears; BORDER_COLOR, default 0, out-of-range read value.
REQ-007 clk_in  input  1  sole clock, all logic on rising edge.
REQ-008 rst_in_n  input  1  asynchronous, active-low reset.
REQ-009 wr_x, wr_y  input  11, 10  stored-frame write coordinate.
REQ-010 wr_pixel  input  PIX_W  write data.
REQ-011 wr_valid  input  1  write request; accepted only when wr_ready=1.
REQ-012 wr_ready  output  1  high when writes are accepted.
REQ-013 frame_done  input  1  one-cycle pulse: write bank complete, request swap.
REQ-014 clear_req  input  1  one-cycle pulse: fill write bank with CLEAR_COLOR.
REQ-015 rd_x, rd_y, rd_valid  input  11, 10, 1  display coordinate and active-video flag.
REQ-016 vsync_in  input  1  one-cycle pulse at start of vertical blank.
REQ-017 pixel_out, pixel_valid_out  output  PIX_W, 1  display pixel and its valid flag.
REQ-018 swap_done, clearing  output  1, 1  one-cycle swap pulse; high while clearing.

Function
REQ-019 Storage SHALL be one dual-port RAM of depth (1+DOUBLE_BUF)*WIDTH*HEIGHT; address = bank*W*H + y*WIDTH + x.
REQ-020 Display bank SHALL be read on port A; write bank (= ~display bank, or 0 if DOUBLE_BUF=0) written on port B.
REQ-021 Read address SHALL be (rd_x>>SCALE_SHIFT) + (rd_y>>SCALE_SHIFT)*WIDTH in display bank.
REQ-022 pixel_out/pixel_valid_out SHALL reflect rd inputs presented exactly 3 cycles earlier (1 address reg + 2 RAM).
REQ-023 Scaled coordinate with x>=WIDTH or y>=HEIGHT, or rd_valid=0, SHALL yield BORDER_COLOR; pixel_valid_out = delayed rd_valid.
REQ-024 Accepted write with wr_x<WIDTH and wr_y<HEIGHT SHALL commit one cycle after acceptance; out-of-range writes SHALL be silently dropped.
REQ-025 FSM states: IDLE, CLEAR, SWAP_WAIT.
REQ-026 IDLE: clear_req -> CLEAR; frame_done (DOUBLE_BUF=1) -> SWAP_WAIT.
REQ-027 CLEAR: wr_ready=0, clearing=1, one CLEAR_COLOR write per cycle, address 0..W*H-1 of write bank; after last address -> IDLE, or SWAP_WAIT if frame_done arrived during clear.
REQ-028 SWAP_WAIT: wr_ready=0; on vsync_in toggle display bank, pulse swap_done same edge, -> IDLE.
REQ-029 frame_done and vsync_in in same IDLE cycle: swap SHALL wait for the next vsync_in.
REQ-030 clear_req in CLEAR or SWAP_WAIT SHALL be ignored; frame_done in SWAP_WAIT ignored.
REQ-031 DOUBLE_BUF=0: frame_done SHALL be ignored; swap_done never asserts.
REQ-032 Address arithmetic SHALL be $clog2(depth) bits wide, no truncation at defaults.

Reset
REQ-033 rst_in_n low SHALL force: state IDLE, display bank 0, pixel_out 0, pixel_valid_out 0, swap_done 0, clearing 0, wr_ready 0, pending frame_done cleared, read pipeline flushed.
REQ-034 wr_ready SHALL rise on the first clock after rst_in_n deasserts; RAM contents undefined after reset.
REQ-035 Reset mid-CLEAR or mid-SWAP_WAIT SHALL abort with no further writes and no swap.

Structure
REQ-036 Shared package fb_pkg SHALL hold the FSM state typedef and default WIDTH/HEIGHT/PIX_W constants.
REQ-037 Storage SHALL instantiate xilinx_true_dual_port_read_first_1_clock_ram (HIGH_PERFORMANCE); no other sub-module.

Verification
REQ-038 Write 12'hABC at (3,2), frame_done, vsync_in; read rd=(6,4) and (7,5) -> pixel_out 12'hABC 3 cycles later, swap_done pulsed once.
REQ-039 rd=(1100,0) at SCALE_SHIFT=1, rd_valid=1 -> BORDER_COLOR, pixel_valid_out=1 3 cycles later.
REQ-040 clear_req then frame_done at cycle 10 -> clearing high W*H cycles, wr_ready 0, swap only on first vsync after clear; all reads of new bank = CLEAR_COLOR.
REQ-041 frame_done and vsync_in same cycle -> no swap; swap_done on next vsync_in.
REQ-042 wr_x=600 write -> no RAM change; rst_in_n pulse at clear address 100 -> clearing 0 immediately, display bank 0.
